// File: rtl/mips_pkg.sv
// Shared MIPS definitions used by the ID/EX stage: ALU control codes, opcode/funct
// values and the control bundles passed between decode and the pipeline register.
package mips_pkg;

    typedef enum logic [2:0] {
        ALU_ADD = 3'b000,
        ALU_SUB = 3'b001,
        ALU_SLL = 3'b010,
        ALU_NOR = 3'b011,
        ALU_AND = 3'b100,
        ALU_SLT = 3'b101
    } alu_ctrl_e;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_SLTI  = 6'h0A;

    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_SLL = 6'h00;
    localparam logic [5:0] FN_NOR = 6'h27;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_SLT = 6'h2A;

    typedef struct packed {
        alu_ctrl_e alu;
        logic      regwrite;
        logic      memread;
        logic      memwrite;
        logic      branch;
        logic      imm_zero_ext;
        logic      uses_rt;
        logic      use_imm;
        logic      dest_is_rt;
        logic      illegal;
    } dec_ctrl_t;

    typedef struct packed {
        logic      valid;
        logic      regwrite;
        logic      memread;
        logic      memwrite;
        logic      branch;
        logic      use_imm;
        logic      illegal;
        alu_ctrl_e alu;
        logic [4:0] rd;
        logic [4:0] rs;
        logic [4:0] rt;
        logic [4:0] shamt;
    } ex_ctrl_t;

    localparam ex_ctrl_t EX_BUBBLE = '0;

endpackage

// File: rtl/id_ex_stage_if.sv
// Signal bundle between ID, the forwarding sources and the ID/EX stage.
// master drives ID fields and forwarding sources; slave is the stage itself.
interface id_ex_stage_if #(parameter int W = 32);

    logic         id_valid;
    logic [5:0]   id_opcode;
    logic [5:0]   id_funct;
    logic [4:0]   id_rs;
    logic [4:0]   id_rt;
    logic [4:0]   id_rd;
    logic [4:0]   id_shamt;
    logic [15:0]  id_imm;
    logic [W-1:0] id_rs_data;
    logic [W-1:0] id_rt_data;
    logic         stall_in;
    logic         flush;
    logic         exm_regwrite;
    logic [4:0]   exm_rd;
    logic [W-1:0] exm_result;
    logic         mwb_regwrite;
    logic [4:0]   mwb_rd;
    logic [W-1:0] mwb_result;

    logic [W-1:0] opA;
    logic [W-1:0] opB;
    logic [4:0]   shamt;
    logic [2:0]   alu_control_signal;
    logic         ex_valid;
    logic         ex_regwrite;
    logic         ex_memread;
    logic         ex_memwrite;
    logic         ex_branch;
    logic [4:0]   ex_rd;
    logic [W-1:0] ex_store_data;
    logic         ex_illegal;
    logic         hazard_stall;

    modport master (
        output id_valid, id_opcode, id_funct, id_rs, id_rt, id_rd, id_shamt, id_imm,
               id_rs_data, id_rt_data, stall_in, flush,
               exm_regwrite, exm_rd, exm_result, mwb_regwrite, mwb_rd, mwb_result,
        input  opA, opB, shamt, alu_control_signal, ex_valid, ex_regwrite, ex_memread,
               ex_memwrite, ex_branch, ex_rd, ex_store_data, ex_illegal, hazard_stall
    );

    modport slave (
        input  id_valid, id_opcode, id_funct, id_rs, id_rt, id_rd, id_shamt, id_imm,
               id_rs_data, id_rt_data, stall_in, flush,
               exm_regwrite, exm_rd, exm_result, mwb_regwrite, mwb_rd, mwb_result,
        output opA, opB, shamt, alu_control_signal, ex_valid, ex_regwrite, ex_memread,
               ex_memwrite, ex_branch, ex_rd, ex_store_data, ex_illegal, hazard_stall
    );

endinterface

// File: rtl/alu_ctrl_decode.sv
// Combinational opcode/funct decode into ALU control code and EX/MEM control bits.
module alu_ctrl_decode
    import mips_pkg::*;
(
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    output dec_ctrl_t  ctrl
);

    always_comb begin : decode
        dec_ctrl_t c;
        c     = '0;
        c.alu = ALU_ADD;
        if (opcode == OP_RTYPE) begin
            c.regwrite = 1'b1;
            c.uses_rt  = 1'b1;
            case (funct)
                FN_ADD:  c.alu = ALU_ADD;
                FN_SUB:  c.alu = ALU_SUB;
                FN_SLL:  c.alu = ALU_SLL;
                FN_NOR:  c.alu = ALU_NOR;
                FN_AND:  c.alu = ALU_AND;
                FN_SLT:  c.alu = ALU_SLT;
                default: c.illegal = 1'b1;
            endcase
        end else begin
            c.use_imm    = 1'b1;
            c.dest_is_rt = 1'b1;
            case (opcode)
                OP_ADDI: c.regwrite = 1'b1;
                OP_LW: begin
                    c.regwrite = 1'b1;
                    c.memread  = 1'b1;
                end
                OP_SW: begin
                    c.memwrite = 1'b1;
                    c.uses_rt  = 1'b1;
                end
                OP_BEQ: begin
                    c.alu     = ALU_SUB;
                    c.branch  = 1'b1;
                    c.uses_rt = 1'b1;
                    c.use_imm = 1'b0;
                end
                OP_ANDI: begin
                    c.alu          = ALU_AND;
                    c.regwrite     = 1'b1;
                    c.imm_zero_ext = 1'b1;
                end
                OP_SLTI: begin
                    c.alu      = ALU_SLT;
                    c.regwrite = 1'b1;
                end
                default: c.illegal = 1'b1;
            endcase
        end
        // Unsupported encodings must not leak any partial control into EX.
        if (c.illegal) begin
            ctrl         = '0;
            ctrl.illegal = 1'b1;
        end else begin
            ctrl = c;
        end
    end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register: captures decoded ID fields, forwards EX/MEM and MEM/WB
// results into the ALU operands, and inserts a bubble on load-use hazards.
module id_ex_stage
    import mips_pkg::*;
#(
    parameter int W = 32
) (
    input logic          clk,
    input logic          rst,
    id_ex_stage_if.slave bus
);

    dec_ctrl_t    id_dec;
    ex_ctrl_t     ctrl_d, ctrl_q;
    logic [W-1:0] rs_data_d, rs_data_q;
    logic [W-1:0] rt_data_d, rt_data_q;
    logic [W-1:0] imm_d, imm_q;
    logic [W-1:0] imm_ext;
    logic [W-1:0] rs_fwd, rt_fwd;
    logic         hazard;

    alu_ctrl_decode u_decode (
        .opcode (bus.id_opcode),
        .funct  (bus.id_funct),
        .ctrl   (id_dec)
    );

    assign imm_ext = id_dec.imm_zero_ext ? {{(W-16){1'b0}}, bus.id_imm}
                                         : {{(W-16){bus.id_imm[15]}}, bus.id_imm};

    // A load sitting in EX has no result yet, so a dependent instruction in ID must wait a cycle.
    assign hazard = ctrl_q.valid && ctrl_q.memread && bus.id_valid && (ctrl_q.rd != 5'd0)
                    && ((ctrl_q.rd == bus.id_rs) || (id_dec.uses_rt && (ctrl_q.rd == bus.id_rt)));

    always_comb begin
        ctrl_d    = ctrl_q;
        rs_data_d = rs_data_q;
        rt_data_d = rt_data_q;
        imm_d     = imm_q;
        if (bus.flush) begin
            ctrl_d    = EX_BUBBLE;
            rs_data_d = '0;
            rt_data_d = '0;
            imm_d     = '0;
        end else if (bus.stall_in) begin
            ctrl_d = ctrl_q;
        end else if (hazard || !bus.id_valid || id_dec.illegal) begin
            ctrl_d         = EX_BUBBLE;
            ctrl_d.illegal = !hazard && bus.id_valid && id_dec.illegal;
            rs_data_d      = '0;
            rt_data_d      = '0;
            imm_d          = '0;
        end else begin
            ctrl_d.valid    = 1'b1;
            ctrl_d.regwrite = id_dec.regwrite;
            ctrl_d.memread  = id_dec.memread;
            ctrl_d.memwrite = id_dec.memwrite;
            ctrl_d.branch   = id_dec.branch;
            ctrl_d.use_imm  = id_dec.use_imm;
            ctrl_d.illegal  = 1'b0;
            ctrl_d.alu      = id_dec.alu;
            ctrl_d.rd       = id_dec.dest_is_rt ? bus.id_rt : bus.id_rd;
            ctrl_d.rs       = bus.id_rs;
            ctrl_d.rt       = bus.id_rt;
            ctrl_d.shamt    = bus.id_shamt;
            rs_data_d       = bus.id_rs_data;
            rt_data_d       = bus.id_rt_data;
            imm_d           = imm_ext;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ctrl_q    <= EX_BUBBLE;
            rs_data_q <= '0;
            rt_data_q <= '0;
            imm_q     <= '0;
        end else begin
            ctrl_q    <= ctrl_d;
            rs_data_q <= rs_data_d;
            rt_data_q <= rt_data_d;
            imm_q     <= imm_d;
        end
    end

    // The younger EX/MEM result takes precedence; register 0 is hardwired and never forwarded.
    function automatic logic [W-1:0] forward_src(
        input logic [4:0]   src,
        input logic [W-1:0] file_data,
        input logic         exm_rw,
        input logic [4:0]   exm_rd,
        input logic [W-1:0] exm_res,
        input logic         mwb_rw,
        input logic [4:0]   mwb_rd,
        input logic [W-1:0] mwb_res
    );
        logic [W-1:0] result;
        result = file_data;
        if (src != 5'd0) begin
            if (exm_rw && (exm_rd == src)) begin
                result = exm_res;
            end else if (mwb_rw && (mwb_rd == src)) begin
                result = mwb_res;
            end
        end
        return result;
    endfunction

    assign rs_fwd = forward_src(ctrl_q.rs, rs_data_q, bus.exm_regwrite, bus.exm_rd, bus.exm_result,
                                bus.mwb_regwrite, bus.mwb_rd, bus.mwb_result);
    assign rt_fwd = forward_src(ctrl_q.rt, rt_data_q, bus.exm_regwrite, bus.exm_rd, bus.exm_result,
                                bus.mwb_regwrite, bus.mwb_rd, bus.mwb_result);

    assign bus.opA                = rs_fwd;
    assign bus.opB                = ctrl_q.use_imm ? imm_q : rt_fwd;
    assign bus.shamt              = ctrl_q.shamt;
    assign bus.alu_control_signal = ctrl_q.alu;
    assign bus.ex_valid           = ctrl_q.valid;
    assign bus.ex_regwrite        = ctrl_q.regwrite;
    assign bus.ex_memread         = ctrl_q.memread;
    assign bus.ex_memwrite        = ctrl_q.memwrite;
    assign bus.ex_branch          = ctrl_q.branch;
    assign bus.ex_rd              = ctrl_q.rd;
    assign bus.ex_store_data      = rt_fwd;
    assign bus.ex_illegal         = ctrl_q.illegal;
    assign bus.hazard_stall       = hazard;

endmodule

// File: tb/tb_id_ex_stage.sv
// Bench for id_ex_stage: directed scenarios followed by random traffic, compared against
// a model that holds the raw instruction sitting in EX and derives outputs from the ISA rules.
module tb_id_ex_stage;

    localparam int W = 32;

    logic clk;
    logic rst;
    int   errors;
    int   checks;

    // Model of EX: the raw instruction currently held, or an all-zero bubble.
    logic        m_valid;
    logic        m_illegal;
    logic [5:0]  m_op;
    logic [5:0]  m_funct;
    logic [4:0]  m_rs;
    logic [4:0]  m_rt;
    logic [4:0]  m_rd;
    logic [4:0]  m_shamt;
    logic [15:0] m_imm;
    logic [31:0] m_rsd;
    logic [31:0] m_rtd;

    logic [5:0] op_tbl [9]    = '{6'h00, 6'h00, 6'h08, 6'h23, 6'h2B, 6'h04, 6'h0C, 6'h0A, 6'h3F};
    logic [5:0] funct_tbl [7] = '{6'h20, 6'h22, 6'h00, 6'h27, 6'h24, 6'h2A, 6'h3F};

    id_ex_stage_if #(.W(W)) bus ();

    id_ex_stage #(.W(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Instruction-set table: what each supported encoding means.
    function automatic void specDecode(input logic [5:0] op, input logic [5:0] funct,
                                       output logic ok, output logic [2:0] alu,
                                       output logic rw, output logic mr, output logic mw,
                                       output logic br, output logic zx, output logic rt_src,
                                       output logic imm_b, output logic dest_rt);
        ok = 1'b1; alu = 3'd0; rw = 1'b0; mr = 1'b0; mw = 1'b0; br = 1'b0;
        zx = 1'b0; rt_src = 1'b0; imm_b = 1'b1; dest_rt = 1'b1;
        if (op == 6'h00) begin
            rw = 1'b1; rt_src = 1'b1; imm_b = 1'b0; dest_rt = 1'b0;
            case (funct)
                6'h20:   alu = 3'd0;
                6'h22:   alu = 3'd1;
                6'h00:   alu = 3'd2;
                6'h27:   alu = 3'd3;
                6'h24:   alu = 3'd4;
                6'h2A:   alu = 3'd5;
                default: ok = 1'b0;
            endcase
        end else begin
            case (op)
                6'h08:   rw = 1'b1;
                6'h23:   begin rw = 1'b1; mr = 1'b1; end
                6'h2B:   begin mw = 1'b1; rt_src = 1'b1; end
                6'h04:   begin alu = 3'd1; br = 1'b1; rt_src = 1'b1; imm_b = 1'b0; end
                6'h0C:   begin alu = 3'd4; rw = 1'b1; zx = 1'b1; end
                6'h0A:   begin alu = 3'd5; rw = 1'b1; end
                default: ok = 1'b0;
            endcase
        end
    endfunction

    function automatic logic [31:0] fwd(input logic [4:0] src, input logic [31:0] file_data);
        if (src != 5'd0 && bus.exm_regwrite && bus.exm_rd == src) return bus.exm_result;
        if (src != 5'd0 && bus.mwb_regwrite && bus.mwb_rd == src) return bus.mwb_result;
        return file_data;
    endfunction

    // A load's destination is its rt field.
    function automatic logic expHazard();
        logic ok, rw, mr, mw, br, zx, rts, ib, drt;
        logic [2:0] alu;
        specDecode(bus.id_opcode, bus.id_funct, ok, alu, rw, mr, mw, br, zx, rts, ib, drt);
        return m_valid && (m_op == 6'h23) && bus.id_valid && (m_rt != 5'd0)
               && ((m_rt == bus.id_rs) || (ok && rts && (m_rt == bus.id_rt)));
    endfunction

    task automatic modelReset();
        m_valid = 1'b0; m_illegal = 1'b0; m_op = '0; m_funct = '0; m_rs = '0; m_rt = '0;
        m_rd = '0; m_shamt = '0; m_imm = '0; m_rsd = '0; m_rtd = '0;
    endtask

    task automatic modelBubble(input logic illegal);
        modelReset();
        m_illegal = illegal;
    endtask

    task automatic modelStep(input logic e_haz);
        logic ok, rw, mr, mw, br, zx, rts, ib, drt;
        logic [2:0] alu;
        specDecode(bus.id_opcode, bus.id_funct, ok, alu, rw, mr, mw, br, zx, rts, ib, drt);
        if (bus.flush) begin
            modelBubble(1'b0);
        end else if (bus.stall_in) begin
        end else if (e_haz) begin
            modelBubble(1'b0);
        end else if (bus.id_valid && ok) begin
            m_valid = 1'b1; m_illegal = 1'b0; m_op = bus.id_opcode; m_funct = bus.id_funct;
            m_rs = bus.id_rs; m_rt = bus.id_rt; m_rd = bus.id_rd; m_shamt = bus.id_shamt;
            m_imm = bus.id_imm; m_rsd = bus.id_rs_data; m_rtd = bus.id_rt_data;
        end else begin
            modelBubble(bus.id_valid);
        end
    endtask

    task automatic checkOutput(input string tag);
        logic ok, rw, mr, mw, br, zx, rts, ib, drt;
        logic [2:0]  alu;
        logic [31:0] e_rt, e_ext;
        specDecode(m_op, m_funct, ok, alu, rw, mr, mw, br, zx, rts, ib, drt);
        if (!m_valid) begin
            alu = 3'd0; rw = 1'b0; mr = 1'b0; mw = 1'b0; br = 1'b0; ib = 1'b0;
        end
        e_rt  = fwd(m_rt, m_rtd);
        e_ext = zx ? {16'h0000, m_imm} : {{16{m_imm[15]}}, m_imm};
        chk({tag, ".opA"}, bus.opA, fwd(m_rs, m_rsd));
        chk({tag, ".opB"}, bus.opB, ib ? e_ext : e_rt);
        chk({tag, ".alu"}, 32'(bus.alu_control_signal), 32'(alu));
        chk({tag, ".shamt"}, 32'(bus.shamt), 32'(m_shamt));
        chk({tag, ".valid"}, 32'(bus.ex_valid), 32'(m_valid));
        chk({tag, ".regwrite"}, 32'(bus.ex_regwrite), 32'(rw));
        chk({tag, ".memread"}, 32'(bus.ex_memread), 32'(mr));
        chk({tag, ".memwrite"}, 32'(bus.ex_memwrite), 32'(mw));
        chk({tag, ".branch"}, 32'(bus.ex_branch), 32'(br));
        chk({tag, ".rd"}, 32'(bus.ex_rd), 32'(drt ? m_rt : m_rd));
        chk({tag, ".store"}, bus.ex_store_data, e_rt);
        chk({tag, ".illegal"}, 32'(bus.ex_illegal), 32'(m_illegal));
        chk({tag, ".hazard"}, 32'(bus.hazard_stall), 32'(expHazard()));
    endtask

    task automatic applyStimulus(input logic valid, input logic [5:0] op, input logic [5:0] funct,
                                 input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                                 input logic [4:0] shamt, input logic [15:0] imm,
                                 input logic [31:0] rsd, input logic [31:0] rtd);
        bus.id_valid = valid; bus.id_opcode = op; bus.id_funct = funct; bus.id_rs = rs;
        bus.id_rt = rt; bus.id_rd = rd; bus.id_shamt = shamt; bus.id_imm = imm;
        bus.id_rs_data = rsd; bus.id_rt_data = rtd;
    endtask

    task automatic setFwd(input logic erw, input logic [4:0] erd, input logic [31:0] eres,
                          input logic mrw, input logic [4:0] mrd, input logic [31:0] mres);
        bus.exm_regwrite = erw; bus.exm_rd = erd; bus.exm_result = eres;
        bus.mwb_regwrite = mrw; bus.mwb_rd = mrd; bus.mwb_result = mres;
    endtask

    // Runs one clock from a falling edge to the next, checking before and after the rising edge.
    task automatic stepCycle(input string tag);
        logic e_haz;
        #1;
        e_haz = expHazard();
        checkOutput({tag, ".pre"});
        @(posedge clk);
        modelStep(e_haz);
        #1;
        checkOutput(tag);
        @(negedge clk);
    endtask

    // Crosses a clock edge with the stage held, so the model stays unchanged.
    task automatic holdSync();
        bus.stall_in = 1'b1;
        @(negedge clk);
        bus.stall_in = 1'b0;
    endtask

    initial begin
        errors = 0;
        checks = 0;
        modelReset();
        rst = 1'b1;
        bus.stall_in = 1'b0;
        bus.flush    = 1'b0;
        applyStimulus(1'b0, 6'h00, 6'h00, 5'd0, 5'd0, 5'd0, 5'd0, 16'h0000, 32'h0, 32'h0);
        setFwd(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        repeat (2) @(negedge clk);
        #1;
        checkOutput("reset");
        rst = 1'b0;
        @(negedge clk);

        $display("[TB] add $3,$1,$2");
        applyStimulus(1'b1, 6'h00, 6'h20, 5'd1, 5'd2, 5'd3, 5'd0, 16'h0000, 32'd5, 32'd7);
        stepCycle("add");
        chk("add.opA5", bus.opA, 32'd5);
        chk("add.opB7", bus.opB, 32'd7);
        chk("add.alu000", 32'(bus.alu_control_signal), 32'd0);
        chk("add.rd3", 32'(bus.ex_rd), 32'd3);
        chk("add.rw1", 32'(bus.ex_regwrite), 32'd1);

        $display("[TB] forwarding priority");
        applyStimulus(1'b0, 6'h00, 6'h00, 5'd0, 5'd0, 5'd0, 5'd0, 16'h0000, 32'h0, 32'h0);
        setFwd(1'b1, 5'd1, 32'hAA, 1'b1, 5'd1, 32'hBB);
        #1 chk("fwd.exm_wins", bus.opA, 32'hAA);
        setFwd(1'b1, 5'd0, 32'hCC, 1'b1, 5'd1, 32'hBB);
        #1 chk("fwd.mwb", bus.opA, 32'hBB);
        setFwd(1'b1, 5'd0, 32'hCC, 1'b0, 5'd1, 32'hBB);
        #1 chk("fwd.rd0_file", bus.opA, 32'd5);
        setFwd(1'b0, 5'd0, 32'h0, 1'b1, 5'd2, 32'hDD);
        #1 chk("fwd.rt_mwb", bus.opB, 32'hDD);
        setFwd(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        holdSync();

        $display("[TB] immediates");
        applyStimulus(1'b1, 6'h08, 6'h00, 5'd1, 5'd4, 5'd0, 5'd0, 16'hFFFF, 32'd5, 32'd7);
        stepCycle("addi");
        chk("addi.opB", bus.opB, 32'hFFFFFFFF);
        chk("addi.alu", 32'(bus.alu_control_signal), 32'd0);
        applyStimulus(1'b1, 6'h0C, 6'h00, 5'd1, 5'd4, 5'd0, 5'd0, 16'hFFFF, 32'd5, 32'd7);
        stepCycle("andi");
        chk("andi.opB", bus.opB, 32'h0000FFFF);
        chk("andi.alu", 32'(bus.alu_control_signal), 32'd4);

        $display("[TB] load-use hazard");
        applyStimulus(1'b1, 6'h23, 6'h00, 5'd1, 5'd5, 5'd0, 5'd0, 16'h0004, 32'h100, 32'h9);
        stepCycle("lw");
        applyStimulus(1'b1, 6'h00, 6'h22, 5'd5, 5'd2, 5'd6, 5'd0, 16'h0000, 32'h11, 32'h22);
        #1 chk("haz.stall", 32'(bus.hazard_stall), 32'd1);
        stepCycle("haz_bubble");
        chk("haz.valid0", 32'(bus.ex_valid), 32'd0);
        chk("haz.memread0", 32'(bus.ex_memread), 32'd0);
        chk("haz.regwrite0", 32'(bus.ex_regwrite), 32'd0);
        setFwd(1'b0, 5'd0, 32'h0, 1'b1, 5'd5, 32'h55);
        stepCycle("sub_after");
        chk("sub.opA_mwb", bus.opA, 32'h55);
        chk("sub.alu", 32'(bus.alu_control_signal), 32'd1);
        setFwd(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);

        $display("[TB] flush and stall");
        applyStimulus(1'b1, 6'h00, 6'h20, 5'd1, 5'd2, 5'd3, 5'd0, 16'h0000, 32'd5, 32'd7);
        bus.stall_in = 1'b1;
        bus.flush    = 1'b1;
        stepCycle("flush_stall");
        chk("flush.valid0", 32'(bus.ex_valid), 32'd0);
        bus.stall_in = 1'b0;
        bus.flush    = 1'b0;
        stepCycle("reload");
        bus.stall_in = 1'b1;
        applyStimulus(1'b1, 6'h2B, 6'h00, 5'd7, 5'd6, 5'd0, 5'd0, 16'h1234, 32'h77, 32'h66);
        for (int k = 0; k < 3; k++) stepCycle("stall_hold");
        chk("stall.opA", bus.opA, 32'd5);
        chk("stall.rd", 32'(bus.ex_rd), 32'd3);
        bus.stall_in = 1'b0;

        $display("[TB] illegal opcode");
        applyStimulus(1'b1, 6'h3F, 6'h00, 5'd1, 5'd2, 5'd3, 5'd0, 16'h0000, 32'd1, 32'd2);
        stepCycle("illegal");
        chk("illegal.valid0", 32'(bus.ex_valid), 32'd0);
        chk("illegal.flag1", 32'(bus.ex_illegal), 32'd1);

        $display("[TB] random traffic");
        for (int i = 0; i < 400; i++) begin
            applyStimulus(($urandom_range(0, 9) != 0),
                          op_tbl[$urandom_range(0, 8)], funct_tbl[$urandom_range(0, 6)],
                          5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                          5'($urandom_range(0, 7)), 5'($urandom), 16'($urandom),
                          $urandom, $urandom);
            bus.stall_in = ($urandom_range(0, 7) == 0);
            bus.flush    = ($urandom_range(0, 9) == 0);
            setFwd(1'($urandom), 5'($urandom_range(0, 7)), $urandom,
                   1'($urandom), 5'($urandom_range(0, 7)), $urandom);
            if (i == 200) begin
                #2 rst = 1'b1;
                #1;
                modelReset();
                checkOutput("rst_mid");
                chk("rst_mid.opA0", bus.opA, 32'd0);
                chk("rst_mid.valid0", 32'(bus.ex_valid), 32'd0);
                @(negedge clk);
                rst = 1'b0;
            end else begin
                stepCycle("rand");
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
